// File: rtl/sprite_anim_renderer.sv
// Positioned, animated, colour-keyed sprite renderer for the VGA pixel path.
// Two-stage pipeline: address/hit at DrawX/DrawY, ROM read, then palette/background mux.
module sprite_anim_renderer #(
  parameter int SPR_W           = 32,
  parameter int SPR_H           = 32,
  parameter int FRAMES          = 4,
  parameter int SCALE_SHIFT     = 1,
  parameter int IDX_W           = 3,
  parameter int TRANSPARENT_IDX = 0,
  parameter int FRAME_TICKS     = 8,
  parameter int ADDR_W          = $clog2(FRAMES * SPR_W * SPR_H),
  parameter int FRAME_W         = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic               vga_clk,
  input  logic               Reset,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  input  logic               frame_start,
  input  logic [9:0]         PosX,
  input  logic [9:0]         PosY,
  input  logic               flip_h,
  input  logic               anim_en,
  input  logic               anim_restart,
  input  logic [3:0]         bg_red,
  input  logic [3:0]         bg_green,
  input  logic [3:0]         bg_blue,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [IDX_W-1:0]   rom_q,
  output logic [IDX_W-1:0]   pal_index,
  input  logic [3:0]         pal_red,
  input  logic [3:0]         pal_green,
  input  logic [3:0]         pal_blue,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic [FRAME_W-1:0] anim_frame
);

  localparam int LXW    = $clog2(SPR_W);
  localparam int LYW    = $clog2(SPR_H);
  localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [10:0] SPAN_X = 11'(SPR_W << SCALE_SHIFT);
  localparam logic [10:0] SPAN_Y = 11'(SPR_H << SCALE_SHIFT);
  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPR_W * SPR_H);

  logic [9:0]        spos_x;
  logic [9:0]        spos_y;
  logic              sflip;
  logic [TICK_W-1:0] tick;

  logic [10:0]       dx;
  logic [10:0]       dy;
  logic              hit;
  logic [LXW-1:0]    lx_raw;
  logic [LXW-1:0]    lx;
  logic [LYW-1:0]    ly;
  logic [ADDR_W-1:0] frame_base;

  logic              hit1;
  logic              blank1;
  logic [3:0]        bg_r1;
  logic [3:0]        bg_g1;
  logic [3:0]        bg_b1;

  // Position/flip only change at frame_start so a frame never tears.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      spos_x     <= '0;
      spos_y     <= '0;
      sflip      <= 1'b0;
      tick       <= '0;
      anim_frame <= '0;
    end else begin
      if (frame_start) begin
        spos_x <= PosX;
        spos_y <= PosY;
        sflip  <= flip_h;
      end
      if (anim_restart) begin
        tick       <= '0;
        anim_frame <= '0;
      end else if (frame_start && anim_en) begin
        if (tick == TICK_W'(FRAME_TICKS - 1)) begin
          tick <= '0;
          if (anim_frame == FRAME_W'(FRAMES - 1))
            anim_frame <= '0;
          else
            anim_frame <= anim_frame + 1'b1;
        end else begin
          tick <= tick + 1'b1;
        end
      end
    end
  end

  // 11-bit differences: bit 10 set means the pixel is left of / above the sprite.
  assign dx  = {1'b0, DrawX} - {1'b0, spos_x};
  assign dy  = {1'b0, DrawY} - {1'b0, spos_y};
  assign hit = ~dx[10] && (dx < SPAN_X) && ~dy[10] && (dy < SPAN_Y);

  assign lx_raw = dx[SCALE_SHIFT +: LXW];
  assign lx     = sflip ? ~lx_raw : lx_raw;
  assign ly     = dy[SCALE_SHIFT +: LYW];

  assign frame_base  = ADDR_W'(anim_frame) * FRAME_SZ;
  assign rom_address = hit ? frame_base + ADDR_W'({ly, lx}) : frame_base;
  assign pal_index   = rom_q;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      hit1   <= 1'b0;
      blank1 <= 1'b0;
      bg_r1  <= '0;
      bg_g1  <= '0;
      bg_b1  <= '0;
    end else begin
      hit1   <= hit;
      blank1 <= blank;
      bg_r1  <= bg_red;
      bg_g1  <= bg_green;
      bg_b1  <= bg_blue;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (!blank1) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (hit1 && (rom_q != IDX_W'(TRANSPARENT_IDX))) begin
      red   <= pal_red;
      green <= pal_green;
      blue  <= pal_blue;
    end else begin
      red   <= bg_r1;
      green <= bg_g1;
      blue  <= bg_b1;
    end
  end

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Scoreboard bench for sprite_anim_renderer: reference model pushes expected
// pixels, a negedge monitor pops and compares them against the DUT output.
module tb_sprite_anim_renderer;

  localparam int SPR_W  = 32;
  localparam int SPR_H  = 32;
  localparam int FRAMES = 4;
  localparam int SSH    = 1;
  localparam int TRN    = 0;
  localparam int FT     = 8;
  localparam int AW     = 12;

  logic          clk = 1'b0;
  logic          Reset;
  logic [9:0]    DrawX, DrawY, PosX, PosY;
  logic          blank, frame_start, flip_h, anim_en, anim_restart;
  logic [3:0]    bg_red, bg_green, bg_blue;
  logic [AW-1:0] rom_address;
  logic [2:0]    rom_q, pal_index;
  logic [3:0]    pal_red, pal_green, pal_blue;
  logic [3:0]    red, green, blue;
  logic [1:0]    anim_frame;

  logic [2:0] rom [4096];
  logic [3:0] pr [8];
  logic [3:0] pg [8];
  logic [3:0] pb [8];

  typedef struct {
    int          due;
    logic [11:0] rgb;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit init = 0;
  int m_spx, m_spy, m_tick, m_frame;
  bit m_flip;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) rom_q <= rom[rom_address];
  assign pal_red   = pr[pal_index];
  assign pal_green = pg[pal_index];
  assign pal_blue  = pb[pal_index];

  sprite_anim_renderer dut (
    .vga_clk(clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .frame_start(frame_start), .PosX(PosX), .PosY(PosY),
    .flip_h(flip_h), .anim_en(anim_en), .anim_restart(anim_restart),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_address(rom_address), .rom_q(rom_q), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue), .anim_frame(anim_frame)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("pixel", {20'd0, red, green, blue}, {20'd0, e.rgb});
    end
  end

  function automatic void model(output int addr, output bit hit);
    int dx, dy, lx, ly;
    dx  = int'(DrawX) - m_spx;
    dy  = int'(DrawY) - m_spy;
    hit = dx >= 0 && dx < SPR_W * (1 << SSH) && dy >= 0 && dy < SPR_H * (1 << SSH);
    lx  = dx / (1 << SSH);
    ly  = dy / (1 << SSH);
    if (m_flip) lx = SPR_W - 1 - lx;
    addr = m_frame * SPR_W * SPR_H;
    if (hit) addr += ly * SPR_W + lx;
  endfunction

  task automatic step(input int exp_addr = -1, input int exp_rgb = -1);
    int addr;
    bit hit;
    exp_t e;
    #1;
    // a reset now also wipes the pixel that would have left on the next edge
    if (Reset && q.size() > 0 && q[$].due == cyc + 1) q[$].rgb = 12'h000;
    model(addr, hit);
    if (init) begin
      chk("rom_address", {20'd0, rom_address}, addr);
      chk("anim_frame", {30'd0, anim_frame}, m_frame);
    end
    if (exp_addr >= 0) chk("rom_address_fixed", {20'd0, rom_address}, exp_addr);
    if (Reset || !blank) e.rgb = 12'h000;
    else if (hit && rom[addr] != TRN)
      e.rgb = {pr[rom[addr]], pg[rom[addr]], pb[rom[addr]]};
    else e.rgb = {bg_red, bg_green, bg_blue};
    if (exp_rgb >= 0) e.rgb = exp_rgb[11:0];
    e.due = cyc + 2;
    q.push_back(e);
    @(posedge clk);
    if (Reset) begin
      m_spx = 0; m_spy = 0; m_flip = 0; m_tick = 0; m_frame = 0;
      init = 1;
    end else begin
      if (frame_start) begin
        m_spx = PosX; m_spy = PosY; m_flip = flip_h;
      end
      if (anim_restart) begin
        m_tick = 0; m_frame = 0;
      end else if (frame_start && anim_en) begin
        m_tick++;
        if (m_tick == FT) begin
          m_tick = 0;
          m_frame = (m_frame + 1) % FRAMES;
        end
      end
    end
    #1;
  endtask

  task automatic pulse(input bit restart = 0);
    frame_start = 1; anim_restart = restart;
    step();
    frame_start = 0; anim_restart = 0;
    step();
  endtask

  task automatic near_sprite();
    DrawX = 10'((m_spx + int'($urandom_range(0, 90)) - 10) & 1023);
    DrawY = 10'((m_spy + int'($urandom_range(0, 90)) - 10) & 1023);
    {bg_red, bg_green, bg_blue} = 12'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 3'($urandom_range(0, 7));
    for (int i = 0; i < 8; i++) begin
      pr[i] = 4'($urandom); pg[i] = 4'($urandom); pb[i] = 4'($urandom);
    end
    pr[2] = 4'hA; pg[2] = 4'hB; pb[2] = 4'hC;

    Reset = 1; blank = 1; frame_start = 0; anim_en = 0; anim_restart = 0;
    PosX = 0; PosY = 0; flip_h = 0;
    DrawX = 10'd500; DrawY = 10'd400;
    {bg_red, bg_green, bg_blue} = 12'hFFF;
    @(posedge clk); #1;
    repeat (3) step(-1, 12'h000);
    Reset = 0;
    repeat (3) step(-1, 12'hFFF);

    PosX = 10'd100; PosY = 10'd50;
    pulse();
    DrawX = 10'd100; DrawY = 10'd50; step(0);
    DrawX = 10'd163; DrawY = 10'd113; step(1023);
    DrawX = 10'd164; {bg_red, bg_green, bg_blue} = 12'h5A5; step(0, 12'h5A5);
    DrawX = 10'd100; DrawY = 10'd164; step(0);

    flip_h = 1; pulse();
    DrawX = 10'd100; DrawY = 10'd50; step(31);
    PosX = 10'd200; step(31);
    step(31);
    pulse();
    step(0);

    anim_en = 1;
    repeat (8) pulse();
    chk("anim_after_8", {30'd0, anim_frame}, 1);
    repeat (24) pulse();
    chk("anim_after_32", {30'd0, anim_frame}, 0);
    repeat (7) pulse();
    pulse(1);
    chk("anim_restart", {30'd0, anim_frame}, 0);
    repeat (7) pulse();
    chk("tick_zeroed", {30'd0, anim_frame}, 0);
    pulse();
    chk("anim_after_restart_8", {30'd0, anim_frame}, 1);

    anim_en = 0; PosX = 10'd100; PosY = 10'd50; flip_h = 0;
    pulse();
    rom[1189] = 3'd0;
    DrawX = 10'd110; DrawY = 10'd60; blank = 1;
    {bg_red, bg_green, bg_blue} = 12'h345;
    step(1189, 12'h345);
    rom[1189] = 3'd2;
    step(1189, 12'hABC);
    blank = 0; step(1189, 12'h000);
    blank = 1;

    repeat (20) begin
      near_sprite(); blank = ~blank; step();
    end

    repeat (3000) begin
      near_sprite();
      if ($urandom_range(0, 19) == 0) begin
        DrawX = 10'($urandom); DrawY = 10'($urandom);
      end
      blank        = $urandom_range(0, 99) < 85;
      frame_start  = $urandom_range(0, 19) == 0;
      anim_en      = $urandom_range(0, 9) != 0;
      anim_restart = $urandom_range(0, 99) == 0;
      Reset        = $urandom_range(0, 199) == 0;
      if ($urandom_range(0, 3) == 0) begin
        PosX = 10'($urandom); PosY = 10'($urandom); flip_h = 1'($urandom);
      end
      step();
    end

    Reset = 0; frame_start = 0; anim_restart = 0; blank = 0;
    repeat (3) step();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_anim_renderer.md
Name: sprite_anim_renderer

Overview:
Parametrised animated-sprite pixel renderer for the VGA path.
- Maps the current DrawX/DrawY onto a SPR_W x SPR_H sprite placed at a latched screen position, with integer power-of-two scaling and optional horizontal flip.
- Selects one of FRAMES animation frames stored back-to-back in an external synchronous sprite ROM.
- Composites palette colour over a supplied background, using a transparent index.
- Replaces the fixed full-screen single-image stretch with positioned, animated, keyed sprites.

Parameters:
- SPR_W, 32, sprite width in texels (power of two).
- SPR_H, 32, sprite height in texels (power of two).
- FRAMES, 4, number of animation frames in ROM.
- SCALE_SHIFT, 1, on-screen scale = 2^SCALE_SHIFT pixels per texel.
- IDX_W, 3, palette index width.
- TRANSPARENT_IDX, 0, palette index treated as see-through.
- FRAME_TICKS, 8, frame_start pulses per animation step (>=1).
- ADDR_W, clog2(FRAMES*SPR_W*SPR_H), ROM address width.

Ports:
- vga_clk, input, 1: pixel clock; all state on rising edge.
- Reset, input, 1: synchronous, active-high.
- DrawX, input, 10: current pixel column.
- DrawY, input, 10: current pixel row.
- blank, input, 1: 1 = active video, 0 = blanking.
- frame_start, input, 1: one-cycle pulse once per video frame (at vsync).
- PosX, input, 10: requested sprite top-left column.
- PosY, input, 10: requested sprite top-left row.
- flip_h, input, 1: requested horizontal mirror.
- anim_en, input, 1: 1 = animation advances.
- anim_restart, input, 1: one-cycle pulse; forces frame 0.
- bg_red, input, 4: background colour, red, aligned with DrawX/DrawY.
- bg_green, input, 4: background colour, green, aligned with DrawX/DrawY.
- bg_blue, input, 4: background colour, blue, aligned with DrawX/DrawY.
- rom_address, output, ADDR_W: sprite ROM address (ROM has 1-cycle read latency).
- rom_q, input, IDX_W: ROM data, valid one cycle after rom_address.
- pal_index, output, IDX_W: index to the external combinational palette; equals rom_q.
- pal_red, input, 4: palette colour, red, same-cycle response to pal_index.
- pal_green, input, 4: palette colour, green, same-cycle response to pal_index.
- pal_blue, input, 4: palette colour, blue, same-cycle response to pal_index.
- red, output, 4: registered pixel colour, red.
- green, output, 4: registered pixel colour, green.
- blue, output, 4: registered pixel colour, blue.
- anim_frame, output, clog2(FRAMES): current animation frame.

Behaviour:
- Reset (synchronous, active-high):
  - red/green/blue = 0, anim_frame = 0, tick counter = 0.
  - Shadow PosX/PosY/flip_h = 0; stage-1 pipeline regs = 0.
  - Reset mid-line: outputs go 0 on the next edge; first valid pixel follows 2 cycles after deassertion.
- Shadow registers: PosX, PosY and flip_h are latched only on cycles with frame_start = 1. Mid-frame changes have no effect until the next frame_start (no tearing).
- Animation:
  - On frame_start with anim_en = 1: tick increments. When tick = FRAME_TICKS-1, tick wraps to 0 and anim_frame advances; FRAMES-1 wraps to 0.
  - anim_en = 0: tick and anim_frame hold.
  - anim_restart: tick = 0, anim_frame = 0. It has priority over a simultaneous frame_start advance; shadow latching still occurs on that frame_start.
- Hit test (cycle n, combinational):
  - dx = DrawX - sPosX, dy = DrawY - sPosY, computed in 11 bits signed.
  - hit = dx >= 0 && dx < SPR_W<<SCALE_SHIFT && dy >= 0 && dy < SPR_H<<SCALE_SHIFT.
  - Sprites partially off the right or bottom edge clip naturally; there is no wrap-around.
- Address (cycle n, combinational from stage 0):
  - lx = dx >> SCALE_SHIFT; if flip then lx = SPR_W-1-lx.
  - ly = dy >> SCALE_SHIFT.
  - rom_address = anim_frame*SPR_W*SPR_H + ly*SPR_W + lx.
  - When hit = 0, rom_address = anim_frame*SPR_W*SPR_H.
- Stage 1 (edge n→n+1): register hit, blank and bg_* alongside the ROM read.
- Output (edge n+1→n+2):
  - If stage-1 blank = 0: output 0.
  - Else if hit = 1 and rom_q != TRANSPARENT_IDX: output pal_*.
  - Else: output stage-1 bg_*.
- Latency: red/green/blue are valid exactly 2 vga_clk cycles after the DrawX/DrawY/blank/bg sample. Throughput is one pixel per cycle with no stalls.
- anim_frame changes only at a frame_start edge, so all pixels in a frame use one frame index.

Test Plan:
- Reset held 3 cycles with blank=1 and bg=F,F,F → red/green/blue = 0 during reset; bg colour appears 2 cycles after Reset drops.
- Defaults; PosX=100, PosY=50, latched by frame_start; DrawX=100, DrawY=50 → rom_address=0. At DrawX=163, DrawY=113 → rom_address=1023. At DrawX=164 → hit=0 and bg is output.
- flip_h=1; DrawX=100, DrawY=50 → rom_address=31. Changing PosX to 200 mid-frame leaves the address unchanged until the next frame_start.
- anim_en=1 with 8 frame_start pulses → anim_frame 0→1. After 32 pulses → back to 0. anim_restart together with the 8th pulse → anim_frame stays 0, tick=0.
- Model ROM returning 0 (transparent) at a hit pixel with bg=3,4,5 → output 3,4,5. ROM returning 2 with pal=A,B,C → output A,B,C, two cycles after the sample.
- blank=0 at a hit opaque pixel → output 0,0,0. blank toggling every cycle → output tracks with exactly 2-cycle delay.
